// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential multiply/divide unit.
// One operation at a time. A shift-add multiplier and a restoring divider
// each produce one bit per cycle, followed by a sign fix-up cycle.
// Build option: define MULDIV_DIV_EN to include the divide path. Without it,
// divide requests complete immediately, leave hi/lo unchanged, and divzero
// stays 0.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divzero,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(WIDTH);

  state_t               state_reg, state_next;
  logic [CW-1:0]        step_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [WIDTH-1:0]     opnd_reg;
  logic                 sign_a_reg, sign_b_reg;
  logic [WIDTH-1:0]     hi_reg, lo_reg;

  // Sign handling at capture: signed ops work on magnitudes.
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;

  assign a_neg = op[0] & a[WIDTH-1];
  assign b_neg = op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Multiply step: conditionally add the multiplicand into the upper half,
  // then shift the whole accumulator right by one. The carry out is kept.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [2*WIDTH-1:0]   prod_fix;

  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                  + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};
  assign prod_fix = (sign_a_reg ^ sign_b_reg) ? -acc_reg : acc_reg;

  logic [2*WIDTH-1:0]   iter_next;
  logic [WIDTH-1:0]     res_hi, res_lo;
  logic                 skip;

`ifdef MULDIV_DIV_EN
  logic                 div_reg;
  logic                 divzero_reg;
  logic [WIDTH:0]       rem_shift, rem_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // Restoring divide step. The accumulator holds {remainder, dividend/quotient}.
  // Shift in the next dividend bit and try subtracting the divisor. A borrow
  // restores the remainder and shifts in a 0 quotient bit.
  assign rem_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, opnd_reg};
  assign div_next  = rem_diff[WIDTH]
                   ? {rem_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                   : {rem_diff[WIDTH-1:0],  acc_reg[WIDTH-2:0], 1'b1};

  // The quotient follows the sign product. The remainder follows the dividend.
  // The most-negative / -1 case wraps back to the most negative value.
  assign quo_fix = (sign_a_reg ^ sign_b_reg) ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
  assign rem_fix = sign_a_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

  assign iter_next = div_reg ? div_next : mul_next;
  assign res_hi    = div_reg ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo    = div_reg ? quo_fix : prod_fix[WIDTH-1:0];
  assign skip      = op[1] && (b == '0);
  assign divzero   = divzero_reg;
`else
  assign iter_next = mul_next;
  assign res_hi    = prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo    = prod_fix[WIDTH-1:0];
  assign skip      = op[1];
  assign divzero   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic. Requests that need no calculation jump straight to DONE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = skip ? DONE : CALC;
      CALC:    if (step_reg == STEP_LAST) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, iterate in CALC, and publish the
  // results on the edge that enters DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_reg    <= '0;
      acc_reg     <= '0;
      opnd_reg    <= '0;
      sign_a_reg  <= 1'b0;
      sign_b_reg  <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
`ifdef MULDIV_DIV_EN
      div_reg     <= 1'b0;
      divzero_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          step_reg   <= '0;
          sign_a_reg <= a_neg;
          sign_b_reg <= b_neg;
`ifdef MULDIV_DIV_EN
          div_reg     <= op[1];
          divzero_reg <= 1'b0;
          if (op[1]) begin
            opnd_reg <= b_mag;
            acc_reg  <= {{WIDTH{1'b0}}, a_mag};
          end else begin
            opnd_reg <= a_mag;
            acc_reg  <= {{WIDTH{1'b0}}, b_mag};
          end
          if (skip) begin
            hi_reg      <= a;
            lo_reg      <= '1;
            divzero_reg <= 1'b1;
          end
`else
          opnd_reg <= a_mag;
          acc_reg  <= {{WIDTH{1'b0}}, b_mag};
`endif
        end
        CALC: if (step_reg != STEP_LAST) begin
          acc_reg  <= iter_next;
          step_reg <= step_reg + CW'(1);
        end
        FIX: begin
          hi_reg <= res_hi;
          lo_reg <= res_lo;
        end
        default: ;
      endcase
    end
  end

  assign state = state_reg;
  assign busy  = (state_reg != IDLE);
  assign done  = (state_reg == DONE);
  assign hi    = hi_reg;
  assign lo    = lo_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: self-checking bench for muldiv_seq (WIDTH=32).
// Expected results are queued when an operation is issued and popped when
// done pulses. Divide checks follow the MULDIV_DIV_EN build option.
module tb_muldiv_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, divzero;
  logic [W-1:0] hi, lo;
  logic [1:0]   state;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  int           obs_lat, obs_busy;
  logic [1:0]   obs_first, obs_prev, obs_done_state;
  logic [W-1:0] obs_hi, obs_lo;
  logic         obs_dz, obs_dz_first, obs_idle_busy, obs_idle_done;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .divzero(divzero), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: full-width products and truncating signed division.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    logic [63:0] p;
    int          sx, sy;
    e.dz  = 1'b0;
    e.lat = W + 2;
    e.hi  = '0;
    e.lo  = '0;
    sx = 0; sy = 0; p = '0;
    if (!o[1]) begin
      p = {{32{o[0] & x[31]}}, x} * {{32{o[0] & y[31]}}, y};
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else begin
`ifdef MULDIV_DIV_EN
      if (y == '0) begin
        e.hi = x; e.lo = '1; e.dz = 1'b1; e.lat = 0;
      end else if (o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        e.hi = '0; e.lo = 32'h8000_0000;
      end else if (o[0]) begin
        sx = x; sy = y;
        e.lo = sx / sy;
        e.hi = sx % sy;
      end else begin
        e.lo = x / y;
        e.hi = x % y;
      end
`else
      e.hi = last_hi; e.lo = last_lo; e.lat = 0;
`endif
    end
    return e;
  endfunction

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Watch one operation from the cycle after its accept edge to the first idle cycle.
  task automatic wait_done();
    obs_lat = 0; obs_busy = 0;
    @(negedge clk);
    obs_first = state; obs_prev = state; obs_dz_first = divzero;
    while (done !== 1'b1 && obs_lat < 200) begin
      if (busy === 1'b1) obs_busy++;
      obs_prev = state;
      @(negedge clk);
      obs_lat++;
    end
    if (busy === 1'b1) obs_busy++;
    obs_done_state = state; obs_hi = hi; obs_lo = lo; obs_dz = divzero;
    @(negedge clk);
    obs_idle_busy = busy; obs_idle_done = done;
  endtask

  task automatic run(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    sb.push_back(model(o, x, y));
    issue(o, x, y);
    wait_done();
    $display("txn op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d lat=%0d", o, x, y, obs_hi, obs_lo, obs_dz, obs_lat);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total++; if (state !== 2'b00) begin bad++; $display("FAIL reset state got=%0d want=0", state); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset done got=%b want=0", done); end
    total++; if (divzero !== 1'b0) begin bad++; $display("FAIL reset divzero got=%b want=0", divzero); end
    total++; if (hi !== '0) begin bad++; $display("FAIL reset hi got=%h want=0", hi); end
    total++; if (lo !== '0) begin bad++; $display("FAIL reset lo got=%h want=0", lo); end
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
    @(posedge clk); @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_hold busy got=%b want=0", busy); end
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_mult();
    logic [1:0]   t_op[11];
    logic [W-1:0] t_a[11];
    logic [W-1:0] t_b[11];
    exp_t         e;
    t_op = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    t_a  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFB, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 0, 0, 0, 0};
    t_b  = '{32'hFFFF_FFFF, 32'd7, 32'd6, 32'hFFFF_FFFA, 32'h8000_0000, 32'hFFFF_FFFF, 32'd12345, 0, 0, 0, 0};
    for (int i = 7; i < 11; i++) begin
      t_op[i] = 2'($urandom_range(0, 1));
      t_a[i]  = $urandom;
      t_b[i]  = $urandom;
    end
    for (int i = 0; i < 11; i++) begin
      run(t_op[i], t_a[i], t_b[i]);
      e = sb.pop_front();
      last_hi = e.hi; last_lo = e.lo;
      total++; if (obs_lat !== e.lat) begin bad++; $display("FAIL mult[%0d] latency got=%0d want=%0d", i, obs_lat, e.lat); end
      total++; if (obs_hi !== e.hi) begin bad++; $display("FAIL mult[%0d] hi got=%h want=%h", i, obs_hi, e.hi); end
      total++; if (obs_lo !== e.lo) begin bad++; $display("FAIL mult[%0d] lo got=%h want=%h", i, obs_lo, e.lo); end
      total++; if (obs_dz !== 1'b0) begin bad++; $display("FAIL mult[%0d] divzero got=%b want=0", i, obs_dz); end
      total++; if (obs_busy !== e.lat + 1) begin bad++; $display("FAIL mult[%0d] busy_cycles got=%0d want=%0d", i, obs_busy, e.lat + 1); end
      total++; if (obs_first !== 2'b01) begin bad++; $display("FAIL mult[%0d] first_state got=%0d want=1", i, obs_first); end
      total++; if (obs_prev !== 2'b10) begin bad++; $display("FAIL mult[%0d] pre_done_state got=%0d want=2", i, obs_prev); end
      total++; if (obs_done_state !== 2'b11) begin bad++; $display("FAIL mult[%0d] done_state got=%0d want=3", i, obs_done_state); end
      total++; if (obs_idle_busy !== 1'b0 || obs_idle_done !== 1'b0) begin bad++; $display("FAIL mult[%0d] after_done busy=%b done=%b want 0 0", i, obs_idle_busy, obs_idle_done); end
    end
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_div();
    logic [1:0]   t_op[7];
    logic [W-1:0] t_a[7];
    logic [W-1:0] t_b[7];
    exp_t         e;
    t_op = '{2'd3, 2'd3, 2'd2, 2'd3, 2'd2, 2'd2, 2'd3};
    t_a  = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'd7, 32'h64, 32'd9, 32'hFFFF_FF9C};
    t_b  = '{32'd2, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd3, 32'hFFFF_FFF9};
    for (int i = 0; i < 7; i++) begin
      run(t_op[i], t_a[i], t_b[i]);
      e = sb.pop_front();
      last_hi = e.hi; last_lo = e.lo;
      total++; if (obs_lat !== e.lat) begin bad++; $display("FAIL div[%0d] latency got=%0d want=%0d", i, obs_lat, e.lat); end
      total++; if (obs_hi !== e.hi) begin bad++; $display("FAIL div[%0d] hi got=%h want=%h", i, obs_hi, e.hi); end
      total++; if (obs_lo !== e.lo) begin bad++; $display("FAIL div[%0d] lo got=%h want=%h", i, obs_lo, e.lo); end
      total++; if (obs_dz !== e.dz) begin bad++; $display("FAIL div[%0d] divzero got=%b want=%b", i, obs_dz, e.dz); end
      total++; if (obs_dz_first !== e.dz) begin bad++; $display("FAIL div[%0d] divzero_after_accept got=%b want=%b", i, obs_dz_first, e.dz); end
      total++; if (obs_busy !== e.lat + 1) begin bad++; $display("FAIL div[%0d] busy_cycles got=%0d want=%0d", i, obs_busy, e.lat + 1); end
    end
  endtask
`else
  task automatic test_div_disabled();
    logic [1:0]   t_op[2];
    logic [W-1:0] t_a[2];
    logic [W-1:0] t_b[2];
    exp_t         e;
    t_op = '{2'd3, 2'd2};
    t_a  = '{32'hFFFF_FFF9, 32'h64};
    t_b  = '{32'd2, 32'd0};
    for (int i = 0; i < 2; i++) begin
      run(t_op[i], t_a[i], t_b[i]);
      e = sb.pop_front();
      total++; if (obs_lat !== 0) begin bad++; $display("FAIL nodiv[%0d] latency got=%0d want=0", i, obs_lat); end
      total++; if (obs_hi !== e.hi) begin bad++; $display("FAIL nodiv[%0d] hi got=%h want=%h", i, obs_hi, e.hi); end
      total++; if (obs_lo !== e.lo) begin bad++; $display("FAIL nodiv[%0d] lo got=%h want=%h", i, obs_lo, e.lo); end
      total++; if (obs_dz !== 1'b0) begin bad++; $display("FAIL nodiv[%0d] divzero got=%b want=0", i, obs_dz); end
      total++; if (obs_first !== 2'b11) begin bad++; $display("FAIL nodiv[%0d] first_state got=%0d want=3", i, obs_first); end
      total++; if (obs_idle_busy !== 1'b0) begin bad++; $display("FAIL nodiv[%0d] after_done busy got=%b want=0", i, obs_idle_busy); end
    end
  endtask
`endif

  task automatic test_abort();
    exp_t e;
    issue(2'd0, 32'd5, 32'd6);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort busy got=%b want=0", busy); end
    total++; if (hi !== '0) begin bad++; $display("FAIL abort hi got=%h want=0", hi); end
    total++; if (lo !== '0) begin bad++; $display("FAIL abort lo got=%h want=0", lo); end
    total++; if (state !== 2'b00) begin bad++; $display("FAIL abort state got=%0d want=0", state); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort done got=%b want=0", done); end
    last_hi = '0; last_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run(2'd0, 32'd5, 32'd6);
    e = sb.pop_front();
    last_hi = e.hi; last_lo = e.lo;
    total++; if (obs_lat !== e.lat) begin bad++; $display("FAIL abort_rerun latency got=%0d want=%0d", obs_lat, e.lat); end
    total++; if (obs_lo !== e.lo) begin bad++; $display("FAIL abort_rerun lo got=%h want=%h", obs_lo, e.lo); end
    total++; if (obs_hi !== e.hi) begin bad++; $display("FAIL abort_rerun hi got=%h want=%h", obs_hi, e.hi); end
  endtask

  task automatic test_back_to_back();
    exp_t         e;
    int           d1, d2, unstable;
    logic [W-1:0] h1, l1;
    d1 = -1; d2 = -1; unstable = 0; h1 = '0; l1 = '0;
    sb.push_back(model(2'd0, 32'd5, 32'd6));
    sb.push_back(model(2'd0, 32'd7, 32'd9));
    op = 2'd0; a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge clk);
    for (int ed = 0; ed < 120 && d2 < 0; ed++) begin
      @(negedge clk);
      if (ed == 3) begin a = 32'd7; b = 32'd9; end
      if (done === 1'b1) begin
        e = sb.pop_front();
        last_hi = e.hi; last_lo = e.lo;
        $display("txn b2b done at edge %0d hi=%h lo=%h", ed, hi, lo);
        total++; if (hi !== e.hi || lo !== e.lo) begin bad++; $display("FAIL b2b result hi=%h lo=%h want hi=%h lo=%h", hi, lo, e.hi, e.lo); end
        if (d1 < 0) begin
          d1 = ed; h1 = hi; l1 = lo;
        end else begin
          d2 = ed;
          start = 1'b0;
        end
      end else if (d1 >= 0 && (hi !== h1 || lo !== l1)) begin
        unstable++;
      end
    end
    start = 1'b0;
    total++; if (d1 !== W + 2) begin bad++; $display("FAIL b2b first_done edge got=%0d want=%0d", d1, W + 2); end
    total++; if (d2 - d1 !== W + 4) begin bad++; $display("FAIL b2b spacing got=%0d want=%0d", d2 - d1, W + 4); end
    total++; if (unstable !== 0) begin bad++; $display("FAIL b2b hold_between_dones got=%0d want=0", unstable); end
    @(negedge clk);
    total++; if (state !== 2'b00) begin bad++; $display("FAIL b2b final_state got=%0d want=0", state); end
  endtask

  initial begin
    test_reset();
    test_mult();
`ifdef MULDIV_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
